gumnut_datapath_p: RTL and testbench

Parametrised successor of the Gumnut processor datapath. It contains:
- a register file with a hardwired-zero r0,
- a write-data source mux with registered memory/port inputs,
- an ALU issued by a start/done handshake,
- a carry/zero flag register with a hardware save/restore stack for interrupt entry and return.

It sits between the control unit, which drives register selects, immediates and ALU opcodes, and the memory/port buses. Data width, register count and flag-stack depth are parameters.

---
 rtl/gumnut_datapath_p.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_gumnut_datapath_p.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gumnut_datapath_p.sv
// gumnut_datapath_p - parametrised Gumnut datapath.
//
// Register file (r0 hardwired to zero), staged memory/port read data feeding
// a write-data mux, a start/done ALU with captured operands, and a carry/zero
// flag register backed by a small save/restore stack for interrupt entry/exit.
//
// Optional build macro: GUMNUT_SERIAL_SHIFT_EN
//   defined   - shift/rotate ops (8..11) run one bit per enabled cycle
//   undefined - barrel shifter, every op completes one cycle after issue
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   clkEn_i                       global enable, low freezes all state
//   rs_sel_i/rs2_sel_i/rd_sel_i   source A, source B, destination indices
//   immed_i, count_i, op2_i       immediate, shift amount, B-operand select
//   ALUOp_i, start_i              ALU operation and issue strobe
//   RegMux_i, RegWrt_i            write-data select and register write enable
//   data_dat_i, port_dat_i        memory / I/O read data (staged one cycle)
//   push_i, pop_i                 flag save / restore
//   res_o, rsr2_o                 ALU result register, reg[rs2_sel_i] read
//   c_o, z_o                      carry / zero flags
//   busy_o, done_o                ALU in progress, one-cycle completion pulse
//   fstack_ovf_o                  sticky flag-stack overflow
module gumnut_datapath_p #(
    parameter int DATA_W       = 8,
    parameter int NREGS        = 8,
    parameter int FSTACK_DEPTH = 4,
    localparam int SEL_W       = $clog2(NREGS),
    localparam int CNT_W       = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clkEn_i,
    input  logic [SEL_W-1:0]  rs_sel_i,
    input  logic [SEL_W-1:0]  rs2_sel_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    input  logic [DATA_W-1:0] immed_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              op2_i,
    input  logic [3:0]        ALUOp_i,
    input  logic              start_i,
    input  logic [1:0]        RegMux_i,
    input  logic              RegWrt_i,
    input  logic [DATA_W-1:0] data_dat_i,
    input  logic [DATA_W-1:0] port_dat_i,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] res_o,
    output logic [DATA_W-1:0] rsr2_o,
    output logic              c_o,
    output logic              z_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              fstack_ovf_o
);
    localparam int SP_W = $clog2(FSTACK_DEPTH + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    logic [DATA_W-1:0] data_q, data_d, port_q, port_d;
    state_t            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cin_q, cin_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              c_q, c_d, z_q, z_d;
    logic [1:0]        fstk_q [FSTACK_DEPTH];
    logic [1:0]        fstk_d [FSTACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] rs_val_s, rs2_val_s, wdata_s;
    logic [DATA_W:0]   alu_s;       // {carry, result}
    logic              step_s;      // serial shift has more bits to go
    logic [1:0]        fstk_top_s;
    logic              full_s;

    // Full ALU: returns {carry, result}; ops 12..15 give all zeros.
    function automatic logic [DATA_W:0] alu_f(input logic [3:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic              cin,
                                              input logic [CNT_W-1:0]  cnt);
        logic [DATA_W:0]     r;
        logic [2*DATA_W-1:0] dbl;
        logic                nz;
        r   = {(DATA_W+1){1'b0}};
        dbl = {(2*DATA_W){1'b0}};
        nz  = (cnt != {CNT_W{1'b0}});
        case (op)
            4'd0: r = {1'b0, a} + {1'b0, b};
            4'd1: r = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
            4'd2: r = {1'b0, a} - {1'b0, b};
            4'd3: r = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
            4'd4: r = {1'b0, a & b};
            4'd5: r = {1'b0, a | b};
            4'd6: r = {1'b0, a ^ b};
            4'd7: r = {1'b0, a & ~b};
            // The extra top bit catches the last bit shifted out of the MSB.
            4'd8: r = {1'b0, a} << cnt;
            4'd9: begin
                dbl = {a, {DATA_W{1'b0}}} >> cnt;
                r   = {dbl[DATA_W-1], dbl[2*DATA_W-1:DATA_W]};
            end
            // Rotates via a doubled word; the last bit out lands at the
            // opposite end of the result.
            4'd10: begin
                dbl = {a, a} << cnt;
                r   = {nz & dbl[DATA_W], dbl[2*DATA_W-1:DATA_W]};
            end
            4'd11: begin
                dbl = {a, a} >> cnt;
                r   = {nz & dbl[DATA_W-1], dbl[DATA_W-1:0]};
            end
            default: r = {(DATA_W+1){1'b0}};
        endcase
        return r;
    endfunction

`ifdef GUMNUT_SERIAL_SHIFT_EN
    // Single-bit shift/rotate step: {bit moved out, shifted word}.
    function automatic logic [DATA_W:0] shift1_f(input logic [1:0]        kind,
                                                 input logic [DATA_W-1:0] w);
        logic [DATA_W:0] r;
        case (kind)
            2'd0:    r = {w, 1'b0};
            2'd1:    r = {w[0], 1'b0, w[DATA_W-1:1]};
            2'd2:    r = {w[DATA_W-1], w[DATA_W-2:0], w[DATA_W-1]};
            2'd3:    r = {w[0], w[0], w[DATA_W-1:1]};
            default: r = {1'b0, w};
        endcase
        return r;
    endfunction
`endif

    // Register reads, write-data mux and stack top/full decode.
    always_comb begin
        rs_val_s  = rf_q[rs_sel_i];
        rs2_val_s = rf_q[rs2_sel_i];
        case (RegMux_i)
            2'b00:   wdata_s = res_q;
            2'b01:   wdata_s = data_q;
            2'b10:   wdata_s = port_q;
            2'b11:   wdata_s = {DATA_W{1'b0}};
            default: wdata_s = {DATA_W{1'b0}};
        endcase
        fstk_top_s = 2'b00;
        for (int i = 0; i < FSTACK_DEPTH; i++) begin
            fstk_top_s = (sp_q == SP_W'(i + 1)) ? fstk_q[i] : fstk_top_s;
        end
        full_s = (sp_q == SP_W'(FSTACK_DEPTH));
    end

    // ALU result for the captured operation, plus serial-shift stepping.
    always_comb begin
        alu_s  = alu_f(op_q, a_q, b_q, cin_q, cnt_q);
        step_s = 1'b0;
`ifdef GUMNUT_SERIAL_SHIFT_EN
        if (op_q[3:2] == 2'b10) begin
            // a_q is the working word; the final step completes the op.
            if (cnt_q == {CNT_W{1'b0}}) begin
                alu_s = {1'b0, a_q};
            end else begin
                alu_s = shift1_f(op_q[1:0], a_q);
            end
            step_s = (cnt_q > CNT_W'(1'b1));
        end else begin
            step_s = 1'b0;
        end
`endif
    end

    // Next-state logic for the register file, FSM, ALU and flag stack.
    always_comb begin
        rf_d    = rf_q;
        data_d  = data_q;
        port_d  = port_q;
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        cin_d   = cin_q;
        res_d   = res_q;
        c_d     = c_q;
        z_d     = z_q;
        fstk_d  = fstk_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        if (clkEn_i) begin
            data_d = data_dat_i;
            port_d = port_dat_i;
            if (RegWrt_i) begin
                rf_d[rd_sel_i] = wdata_s;
            end else begin
                rf_d = rf_q;
            end
            rf_d[0] = {DATA_W{1'b0}};

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_EXEC;
                        busy_d  = 1'b1;
                        op_d    = ALUOp_i;
                        a_d     = rs_val_s;
                        b_d     = op2_i ? rs2_val_s : immed_i;
                        cnt_d   = count_i;
                        cin_d   = c_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (step_s) begin
                        a_d   = alu_s[DATA_W-1:0];
                        cnt_d = cnt_q - CNT_W'(1'b1);
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        res_d   = alu_s[DATA_W-1:0];
                        // Ops 12..15 clear the result but leave the flags.
                        if (op_q[3:2] != 2'b11) begin
                            c_d = alu_s[DATA_W];
                            z_d = (alu_s[DATA_W-1:0] == {DATA_W{1'b0}});
                        end else begin
                            c_d = c_q;
                            z_d = z_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase

            // Stack pushes save the flags as they stand before this edge; a
            // pop is evaluated last so its restore wins over an ALU update.
            if (push_i && !pop_i) begin
                if (full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    sp_d = sp_q + SP_W'(1'b1);
                    for (int i = 0; i < FSTACK_DEPTH; i++) begin
                        fstk_d[i] = (sp_q == SP_W'(i)) ? {c_q, z_q} : fstk_q[i];
                    end
                end
            end else if (pop_i && !push_i) begin
                if (sp_q != {SP_W{1'b0}}) begin
                    c_d  = fstk_top_s[1];
                    z_d  = fstk_top_s[0];
                    sp_d = sp_q - SP_W'(1'b1);
                end else begin
                    sp_d = sp_q;
                end
            end else begin
                sp_d = sp_q;
            end
        end else begin
            done_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= {DATA_W{1'b0}};
            end
            for (int i = 0; i < FSTACK_DEPTH; i++) begin
                fstk_q[i] <= 2'b00;
            end
            data_q  <= {DATA_W{1'b0}};
            port_q  <= {DATA_W{1'b0}};
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= 4'd0;
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            cin_q   <= 1'b0;
            res_q   <= {DATA_W{1'b0}};
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            sp_q    <= {SP_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            rf_q    <= rf_d;
            fstk_q  <= fstk_d;
            data_q  <= data_d;
            port_q  <= port_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            c_q     <= c_d;
            z_q     <= z_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign res_o        = res_q;
    assign rsr2_o       = rs2_val_s;
    assign c_o          = c_q;
    assign z_o          = z_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fstack_ovf_o = ovf_q;
endmodule

// File: tb/tb_gumnut_datapath_p.sv
// Directed testbench for gumnut_datapath_p (DATA_W=8, NREGS=8, FSTACK_DEPTH=2).
module tb_gumnut_datapath_p;
    localparam int DATA_W       = 8;
    localparam int NREGS        = 8;
    localparam int FSTACK_DEPTH = 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       clkEn_i = 1'b1;
    logic [2:0] rs_sel_i = 3'd0, rs2_sel_i = 3'd0, rd_sel_i = 3'd0;
    logic [7:0] immed_i = 8'h00;
    logic [2:0] count_i = 3'd0;
    logic       op2_i = 1'b0;
    logic [3:0] ALUOp_i = 4'd0;
    logic       start_i = 1'b0;
    logic [1:0] RegMux_i = 2'b00;
    logic       RegWrt_i = 1'b0;
    logic [7:0] data_dat_i = 8'h00, port_dat_i = 8'h00;
    logic       push_i = 1'b0, pop_i = 1'b0;
    logic [7:0] res_o, rsr2_o;
    logic       c_o, z_o, busy_o, done_o, fstack_ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    gumnut_datapath_p #(.DATA_W(DATA_W), .NREGS(NREGS), .FSTACK_DEPTH(FSTACK_DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clkEn_i(clkEn_i),
        .rs_sel_i(rs_sel_i), .rs2_sel_i(rs2_sel_i), .rd_sel_i(rd_sel_i),
        .immed_i(immed_i), .count_i(count_i), .op2_i(op2_i), .ALUOp_i(ALUOp_i),
        .start_i(start_i), .RegMux_i(RegMux_i), .RegWrt_i(RegWrt_i),
        .data_dat_i(data_dat_i), .port_dat_i(port_dat_i),
        .push_i(push_i), .pop_i(pop_i),
        .res_o(res_o), .rsr2_o(rsr2_o), .c_o(c_o), .z_o(z_o),
        .busy_o(busy_o), .done_o(done_o), .fstack_ovf_o(fstack_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic read_reg(input logic [2:0] sel, input string tag, input logic [7:0] exp);
        rs2_sel_i = sel;
        #1;
        check_eq(tag, {24'd0, rsr2_o}, {24'd0, exp});
    endtask

    task automatic load_reg(input logic [2:0] rd, input logic [7:0] val);
        port_dat_i = val;
        step();
        RegMux_i = 2'b10; rd_sel_i = rd; RegWrt_i = 1'b1;
        step();
        RegWrt_i = 1'b0;
    endtask

    task automatic write_res(input logic [2:0] rd, input logic [1:0] mux);
        RegMux_i = mux; rd_sel_i = rd; RegWrt_i = 1'b1;
        step();
        RegWrt_i = 1'b0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [2:0] rs, input logic use_reg,
                          input logic [2:0] rs2, input logic [7:0] imm, input logic [2:0] cnt);
        ALUOp_i = op; rs_sel_i = rs; op2_i = use_reg; rs2_sel_i = rs2;
        immed_i = imm; count_i = cnt;
    endtask

    // Issue and wait (bounded) for done_o.
    task automatic run_op(input logic [3:0] op, input logic [2:0] rs, input logic use_reg,
                          input logic [2:0] rs2, input logic [7:0] imm, input logic [2:0] cnt);
        logic seen;
        seen = 1'b0;
        set_op(op, rs, use_reg, rs2, imm, cnt);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic chk_flags(input string tag, input logic c, input logic z);
        check_eq(tag, {30'd0, c_o, z_o}, {30'd0, c, z});
    endtask

    // Flag setters using r1 = 0xF0.
    task automatic set_f11(); run_op(4'd0, 3'd1, 1'b0, 3'd0, 8'h10, 3'd0); endtask
    task automatic set_f01(); run_op(4'd4, 3'd1, 1'b0, 3'd0, 8'h0F, 3'd0); endtask
    task automatic set_f10(); run_op(4'd0, 3'd1, 1'b0, 3'd0, 8'h20, 3'd0); endtask
    task automatic set_f00(); run_op(4'd6, 3'd1, 1'b0, 3'd0, 8'h00, 3'd0); endtask

    task automatic do_push(); push_i = 1'b1; step(); push_i = 1'b0; endtask
    task automatic do_pop();  pop_i = 1'b1;  step(); pop_i = 1'b0;  endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        // Reset state
        step(); step();
        rst_i = 1'b0;
        step();
        check_eq("rst_res", {24'd0, res_o}, 32'h0);
        chk_flags("rst_flags", 1'b0, 1'b0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_eq("rst_ovf", {31'd0, fstack_ovf_o}, 32'd0);
        for (int r = 0; r < NREGS; r++) begin
            read_reg(3'(r), "rst_reg", 8'h00);
        end

        // Port/memory staging and write mux
        load_reg(3'd1, 8'hF0);
        read_reg(3'd1, "r1_port", 8'hF0);
        data_dat_i = 8'h11;
        step();
        data_dat_i = 8'h22;
        RegMux_i = 2'b01; rd_sel_i = 3'd3; RegWrt_i = 1'b1;
        step();
        RegWrt_i = 1'b0;
        read_reg(3'd3, "r3_staged", 8'h11);
        write_res(3'd2, 2'b01);
        read_reg(3'd2, "r2_data", 8'h22);

        // addc 0xF0 + 0x10 + 0 with exact latency
        set_op(4'd1, 3'd1, 1'b0, 3'd0, 8'h10, 3'd0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_eq("addc_busy", {31'd0, busy_o}, 32'd1);
        check_eq("addc_nodone", {31'd0, done_o}, 32'd0);
        step();
        check_eq("addc_done", {31'd0, done_o}, 32'd1);
        check_eq("addc_busy_end", {31'd0, busy_o}, 32'd0);
        check_eq("addc_res", {24'd0, res_o}, 32'h00);
        chk_flags("addc_flags", 1'b1, 1'b1);
        step();
        check_eq("done_pulse", {31'd0, done_o}, 32'd0);

        // subc 0x05 - 0x06 - 1
        load_reg(3'd4, 8'h05);
        run_op(4'd3, 3'd4, 1'b0, 3'd0, 8'h06, 3'd0);
        check_eq("subc_res", {24'd0, res_o}, 32'hFE);
        chk_flags("subc_flags", 1'b1, 1'b0);

        // xor with register operand B
        run_op(4'd6, 3'd1, 1'b1, 3'd4, 8'h00, 3'd0);
        check_eq("xor_res", {24'd0, res_o}, 32'hF5);
        chk_flags("xor_flags", 1'b0, 1'b0);
        write_res(3'd0, 2'b00);
        read_reg(3'd0, "r0_zero", 8'h00);
        write_res(3'd5, 2'b00);
        read_reg(3'd5, "r5_res", 8'hF5);
        write_res(3'd5, 2'b11);
        read_reg(3'd5, "r5_zero", 8'h00);

        // sub without borrow
        run_op(4'd2, 3'd1, 1'b0, 3'd0, 8'hF0, 3'd0);
        check_eq("sub_res", {24'd0, res_o}, 32'h00);
        chk_flags("sub_flags", 1'b0, 1'b1);

        // Shifts and rotates
        load_reg(3'd6, 8'h81);
        run_op(4'd11, 3'd6, 1'b0, 3'd0, 8'h00, 3'd1);
        check_eq("ror1_res", {24'd0, res_o}, 32'hC0);
        chk_flags("ror1_flags", 1'b1, 1'b0);
        run_op(4'd9, 3'd6, 1'b0, 3'd0, 8'h00, 3'd0);
        check_eq("shr0_res", {24'd0, res_o}, 32'h81);
        chk_flags("shr0_flags", 1'b0, 1'b0);
        run_op(4'd8, 3'd6, 1'b0, 3'd0, 8'h00, 3'd1);
        check_eq("shl1_res", {24'd0, res_o}, 32'h02);
        chk_flags("shl1_flags", 1'b1, 1'b0);
        run_op(4'd12, 3'd6, 1'b0, 3'd0, 8'h00, 3'd0);
        check_eq("op12_res", {24'd0, res_o}, 32'h00);
        chk_flags("op12_flags", 1'b1, 1'b0);

        // Clock enable low: no issue, no write
        clkEn_i = 1'b0;
        set_op(4'd0, 3'd1, 1'b0, 3'd0, 8'h01, 3'd0);
        start_i = 1'b1;
        port_dat_i = 8'h77; RegMux_i = 2'b10; rd_sel_i = 3'd5; RegWrt_i = 1'b1;
        step();
        check_eq("en_noissue", {31'd0, busy_o}, 32'd0);
        clkEn_i = 1'b1; RegWrt_i = 1'b0; start_i = 1'b0;
        read_reg(3'd5, "en_nowrite", 8'h00);
        // Clock enable low during EXEC
        start_i = 1'b1;
        step();
        start_i = 1'b0; clkEn_i = 1'b0;
        step();
        check_eq("en_hold_busy", {31'd0, busy_o}, 32'd1);
        check_eq("en_hold_done", {31'd0, done_o}, 32'd0);
        clkEn_i = 1'b1;
        step();
        check_eq("en_resume_done", {31'd0, done_o}, 32'd1);
        check_eq("en_resume_res", {24'd0, res_o}, 32'hF1);

        // Flag stack (depth 2)
        set_f11(); do_push();
        set_f01(); do_push();
        check_eq("ovf_before", {31'd0, fstack_ovf_o}, 32'd0);
        set_f10(); do_push();
        check_eq("ovf_after", {31'd0, fstack_ovf_o}, 32'd1);
        chk_flags("push_full_flags", 1'b1, 1'b0);
        set_f00(); do_pop();
        chk_flags("pop1", 1'b0, 1'b1);
        do_pop();
        chk_flags("pop2", 1'b1, 1'b1);
        set_f00(); do_pop();
        chk_flags("pop_empty", 1'b0, 1'b0);
        check_eq("ovf_sticky", {31'd0, fstack_ovf_o}, 32'd1);
        set_f10(); do_push();
        set_f01();
        push_i = 1'b1; pop_i = 1'b1;
        step();
        push_i = 1'b0; pop_i = 1'b0;
        chk_flags("pushpop_flags", 1'b0, 1'b1);
        do_pop();
        chk_flags("pushpop_stack", 1'b1, 1'b0);
        // Pop restore wins over ALU completion in the same cycle
        set_f11(); do_push();
        set_op(4'd6, 3'd1, 1'b0, 3'd0, 8'h00, 3'd0);
        start_i = 1'b1;
        step();
        start_i = 1'b0; pop_i = 1'b1;
        step();
        pop_i = 1'b0;
        check_eq("prio_done", {31'd0, done_o}, 32'd1);
        check_eq("prio_res", {24'd0, res_o}, 32'hF0);
        chk_flags("prio_flags", 1'b1, 1'b1);

`ifdef GUMNUT_SERIAL_SHIFT_EN
        // Serial ror 0x81 by 7, with an ignored start mid-shift
        set_op(4'd11, 3'd6, 1'b0, 3'd0, 8'h00, 3'd7);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy_o) nb++;
            if (nb == 3) begin
                ALUOp_i = 4'd0; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            step();
            if (done_o) break;
        end
        start_i = 1'b0;
        check_eq("ser_busy_cycles", nb, 32'd7);
        check_eq("ser_done", {31'd0, done_o}, 32'd1);
        check_eq("ser_res", {24'd0, res_o}, 32'h03);
        step();
        check_eq("ser_ignored", {31'd0, busy_o}, 32'd0);
        // Reset during a serial shift
        set_op(4'd11, 3'd6, 1'b0, 3'd0, 8'h00, 3'd7);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step(); step();
`else
        // Reset during EXEC
        nb = 0;
        set_op(4'd0, 3'd1, 1'b0, 3'd0, 8'h01, 3'd0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
`endif
        check_eq("mid_busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        step();
        check_eq("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done_o}, 32'd0);
        check_eq("mid_rst_res", {24'd0, res_o}, 32'h00);
        check_eq("mid_rst_ovf", {31'd0, fstack_ovf_o}, 32'd0);
        rst_i = 1'b0;
        step();
        check_eq("mid_rst_nodone", {31'd0, done_o}, 32'd0);
        read_reg(3'd1, "mid_rst_reg", 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
